// File: rtl/event_tx_encoder_pkg.sv
// Shared UART link constants: event character codes, event vector layout, selector states.
// Also used by the receive-side comparator, so codes live here rather than in the encoder.
package event_tx_encoder_pkg;

    localparam logic [7:0] CHAR_LOST  = 8'h4C;
    localparam logic [7:0] CHAR_HIT   = 8'h48;
    localparam logic [7:0] CHAR_READY = 8'h52;

    localparam int unsigned EV_W     = 3;
    localparam int unsigned EV_LOST  = 2;
    localparam int unsigned EV_HIT   = 1;
    localparam int unsigned EV_READY = 0;

    localparam int unsigned    IDX_W      = 4;
    localparam logic [IDX_W-1:0] FRAME_LAST = 4'd9;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SEND = 2'd2
    } sel_state_e;

    // Highest-priority pending event's character: lost > hit > ready.
    function automatic logic [7:0] char_for(input logic [EV_W-1:0] pend);
        if (pend[EV_LOST])     return CHAR_LOST;
        else if (pend[EV_HIT]) return CHAR_HIT;
        else                   return CHAR_READY;
    endfunction

    // Flags consumed when loading; a lost frame supersedes hit and ready.
    function automatic logic [EV_W-1:0] clear_mask(input logic [EV_W-1:0] pend);
        if (pend[EV_LOST])     return 3'b111;
        else if (pend[EV_HIT]) return 3'b010;
        else if (pend[EV_READY]) return 3'b001;
        else                   return 3'b000;
    endfunction

endpackage

// File: rtl/event_tx_encoder_uart_tx_core.sv
// 8N1 UART serializer: latches a byte on start, shifts start/data(LSB first)/stop,
// each bit DIV clocks; busy spans the whole frame, done_tick marks its final cycle.
module uart_tx_core
    import event_tx_encoder_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done_tick
);

    localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       data_q, data_n;
    logic             tx_n, busy_n, done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            idx       <= '0;
            data_q    <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            idx       <= idx_n;
            data_q    <= data_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done_tick <= done_n;
        end
    end

    // Next bit timing; done is computed from next state so it lands on the last stop-bit cycle.
    always_comb begin
        cnt_n  = cnt;
        idx_n  = idx;
        data_n = data_q;
        tx_n   = tx;
        busy_n = busy;
        if (busy) begin
            if (cnt == CNT_LAST) begin
                cnt_n = '0;
                if (idx == FRAME_LAST) begin
                    busy_n = 1'b0;
                    tx_n   = 1'b1;
                end else begin
                    idx_n = idx + 4'd1;
                    tx_n  = (idx_n == FRAME_LAST) ? 1'b1 : data_q[3'(idx_n - 4'd1)];
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end else if (start) begin
            busy_n = 1'b1;
            tx_n   = 1'b0;
            cnt_n  = '0;
            idx_n  = '0;
            data_n = data;
        end
        done_n = busy_n && (idx_n == FRAME_LAST) && (cnt_n == CNT_LAST);
    end

endmodule

// File: rtl/event_tx_encoder.sv
// Game-event link transmitter: edge-detects local events, queues one pending request
// per event type, and sends the highest-priority character over an 8N1 UART.
module event_tx_encoder
    import event_tx_encoder_pkg::*;
#(
    parameter int unsigned CLK_HZ = 65_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic multiplayer,
    input  logic player_ready,
    input  logic player_hit,
    input  logic game_over,
    output logic tx,
    output logic tx_busy,
    output logic tx_done_tick
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    logic [EV_W-1:0] ev_cur, ev_prev, pend, pend_n, rise_c, clr_c;
    sel_state_e      state, state_n;
    logic            start_c;
    logic [7:0]      char_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_cur  <= '0;
            ev_prev <= '0;
            pend    <= '0;
            state   <= SEL_IDLE;
        end else begin
            ev_cur  <= {game_over, player_hit, player_ready};
            ev_prev <= ev_cur;
            pend    <= pend_n;
            state   <= state_n;
        end
    end

    assign rise_c = ev_cur & ~ev_prev;

    // Selector: pick a character when the serializer is free; new edges re-arm after the clear.
    always_comb begin
        state_n = state;
        start_c = 1'b0;
        clr_c   = '0;
        char_c  = char_for(pend);
        case (state)
            SEL_IDLE: begin
                if ((pend != '0) && !tx_busy) state_n = SEL_LOAD;
            end
            SEL_LOAD: begin
                if (pend != '0) begin
                    start_c = 1'b1;
                    clr_c   = clear_mask(pend);
                    state_n = SEL_SEND;
                end else begin
                    // Link disabled between selection and load: nothing left to send.
                    state_n = SEL_IDLE;
                end
            end
            SEL_SEND: begin
                if (tx_done_tick) state_n = SEL_IDLE;
            end
            default: state_n = SEL_IDLE;
        endcase
        pend_n = multiplayer ? ((pend & ~clr_c) | rise_c) : '0;
    end

    uart_tx_core #(.DIV(DIV)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .data      (char_c),
        .start     (start_c),
        .tx        (tx),
        .busy      (tx_busy),
        .done_tick (tx_done_tick)
    );

endmodule

// File: tb/tb_event_tx_encoder.sv
// Bench for event_tx_encoder: a line monitor decodes UART frames and checks bit timing,
// directed scenarios plus random event bursts are compared against expected characters.
module tb_event_tx_encoder;

    localparam int unsigned CLK_HZ = 100;
    localparam int unsigned BAUD   = 10;
    localparam int unsigned DIV    = 10;
    localparam logic [7:0]  C_L    = 8'h4C;
    localparam logic [7:0]  C_H    = 8'h48;
    localparam logic [7:0]  C_R    = 8'h52;

    logic clk = 1'b0;
    logic rst, multiplayer, player_ready, player_hit, game_over;
    logic tx, tx_busy, tx_done_tick;

    event_tx_encoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplayer  (multiplayer),
        .player_ready (player_ready),
        .player_hit   (player_hit),
        .game_over    (game_over),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_q[$];
    int unsigned rx_start_q[$];
    int unsigned rx_done_q[$];
    int unsigned last_start, last_done;

    bit          mon_active = 1'b0;
    int          mon_bit, mon_cnt;
    logic [9:0]  mon_bits;
    int unsigned mon_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line monitor: decodes each frame and checks bit stability, busy and done timing.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_bit    = 0;
                    mon_cnt    = 0;
                    mon_start  = cyc;
                    mon_bits   = '0;
                    chk("busy_at_start", 32'(tx_busy), 32'd1);
                end else begin
                    chk("idle_tx", 32'(tx), 32'd1);
                    chk("idle_busy", 32'(tx_busy), 32'd0);
                    chk("idle_done", 32'(tx_done_tick), 32'd0);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == DIV) begin
                    mon_cnt = 0;
                    mon_bit++;
                end
                if (mon_cnt == 0) mon_bits[mon_bit] = tx;
                else chk("bit_stable", 32'(tx), 32'(mon_bits[mon_bit]));
                chk("frame_busy", 32'(tx_busy), 32'd1);
                chk("frame_done", 32'(tx_done_tick),
                    32'((mon_bit == 9) && (mon_cnt == DIV - 1)));
                if ((mon_bit == 9) && (mon_cnt == DIV - 1)) begin
                    chk("stop_bit", 32'(mon_bits[9]), 32'd1);
                    rx_q.push_back(mon_bits[8:1]);
                    rx_start_q.push_back(mon_start);
                    rx_done_q.push_back(cyc);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_events(input logic [2:0] mask, input int width);
        game_over    = mask[2];
        player_hit   = mask[1];
        player_ready = mask[0];
        step(width);
        game_over    = 1'b0;
        player_hit   = 1'b0;
        player_ready = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_arrived"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_bit(input int b, input int budget, input string tag);
        int k = 0;
        while (!(mon_active && (mon_bit >= b)) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_reached"}, 32'(mon_active && (mon_bit >= b)), 32'd1);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        if (rx_q.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            last_start = rx_start_q.pop_front();
            last_done  = rx_done_q.pop_front();
            chk(tag, 32'(rx_q.pop_front()), 32'(exp));
        end
    endtask

    task automatic expect_quiet(input int n, input string tag);
        step(n);
        chk(tag, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
        rx_start_q.delete();
        rx_done_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned done1;
        logic [7:0]  exp_q[$];
        logic [2:0]  mask;
        bit          mp;

        rst = 1'b0; multiplayer = 1'b0;
        player_ready = 1'b0; player_hit = 1'b0; game_over = 1'b0;
        step(3);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done", 32'(tx_done_tick), 32'd0);
        rst = 1'b1; multiplayer = 1'b1;
        step(5);

        // Single hit frame: exact latency and frame length.
        k = cyc + 1;
        drive_events(3'b010, 3);
        wait_frames(1, 150, "hit");
        expect_byte("hit_char", C_H);
        chk("hit_start_cyc", last_start, k + 3);
        chk("hit_done_cyc", last_done, k + 3 + 10 * DIV - 1);
        expect_quiet(20, "hit_quiet");

        // Simultaneous ready + hit: hit first, ready right after.
        drive_events(3'b011, 2);
        wait_frames(2, 300, "hr");
        expect_byte("hr_first", C_H);
        done1 = last_done;
        expect_byte("hr_second", C_R);
        chk("hr_gap", 32'((last_start - done1) <= 3), 32'd1);
        expect_quiet(130, "hr_quiet");

        // Lost arrives during a ready frame with hit pending: hit is dropped.
        drive_events(3'b001, 2);
        wait_bit(2, 40, "rl_active");
        drive_events(3'b010, 2);
        step(5);
        drive_events(3'b100, 2);
        wait_frames(2, 400, "rl");
        expect_byte("rl_first", C_R);
        expect_byte("rl_second", C_L);
        expect_quiet(130, "rl_quiet");

        // Three hit pulses inside one hit frame merge into a single follow-up.
        drive_events(3'b010, 2);
        wait_bit(0, 40, "hh_active");
        step(15); drive_events(3'b010, 1);
        step(10); drive_events(3'b010, 1);
        step(10); drive_events(3'b010, 1);
        wait_frames(2, 400, "hh");
        expect_byte("hh_first", C_H);
        expect_byte("hh_second", C_H);
        expect_quiet(130, "hh_quiet");

        // Link disabled: events ignored, line stays idle.
        multiplayer = 1'b0;
        for (int i = 0; i < 200; i++) begin
            game_over    = 1'($urandom_range(0, 1));
            player_hit   = 1'($urandom_range(0, 1));
            player_ready = 1'($urandom_range(0, 1));
            step(1);
            chk("mp0_tx", 32'(tx), 32'd1);
            chk("mp0_busy", 32'(tx_busy), 32'd0);
        end
        game_over = 1'b0; player_hit = 1'b0; player_ready = 1'b0;
        step(3);
        multiplayer = 1'b1;
        expect_quiet(150, "mp0_quiet");

        // Reset in the middle of a frame aborts it immediately.
        drive_events(3'b001, 2);
        wait_bit(4, 80, "abort_bit4");
        #2 rst = 1'b0;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        step(3);
        rst = 1'b1;
        expect_quiet(200, "abort_quiet");

        // An input already high at reset release yields one request.
        rst = 1'b0;
        player_ready = 1'b1;
        step(2);
        rst = 1'b1;
        wait_frames(1, 150, "held");
        expect_byte("held_char", C_R);
        player_ready = 1'b0;
        expect_quiet(130, "held_quiet");

        // Random simultaneous bursts against the priority/supersede rules.
        for (int it = 0; it < 12; it++) begin
            mask = 3'($urandom_range(1, 7));
            mp   = ($urandom_range(0, 3) != 0);
            multiplayer = mp;
            step(3);
            drive_events(mask, int'($urandom_range(1, 4)));
            exp_q.delete();
            if (mp) begin
                if (mask[2]) exp_q.push_back(C_L);
                else begin
                    if (mask[1]) exp_q.push_back(C_H);
                    if (mask[0]) exp_q.push_back(C_R);
                end
            end
            if (exp_q.size() > 0) wait_frames(exp_q.size(), 400, "rnd");
            foreach (exp_q[j]) expect_byte("rnd_char", exp_q[j]);
            expect_quiet(130, "rnd_quiet");
            multiplayer = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
